// File: rtl/mem_load_bridge.sv
// ============================================================================
// Module      : mem_load_bridge
// Description : Host-to-RAM image loader. Unpacks WORD_W host words into
//               LANE_W RAM writes at consecutive addresses and holds the CPU
//               in reset while the image is loading.
//               Optional macro: LOAD_CHECKSUM_EN (16-bit sum of written lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_bridge #(
    parameter int WORD_W    = 32,
    parameter int LANE_W    = 8,
    parameter int ADDR_W    = 18,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wren,
    input  logic [WORD_W-1:0] data,
    input  logic              last,
    output logic              ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [LANE_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cpu_hold,
    output logic [15:0]       checksum
);

    localparam int c_LANES   = WORD_W / LANE_W;
    localparam int c_LANE_CW = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [c_LANE_CW-1:0] c_LAST_LANE = c_LANE_CW'(c_LANES - 1);
    localparam logic [ADDR_W-1:0]    c_ADDR_MAX  = {ADDR_W{1'b1}};

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCEPT = 2'd1;
    localparam logic [1:0] c_S_UNPACK = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]           r_state;
    logic [WORD_W-1:0]    r_word;
    logic                 r_last;
    logic [c_LANE_CW-1:0] r_lane;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_overflow;

    logic [1:0]           w_state_nxt;
    logic                 w_ready;
    logic                 w_we;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_xfer;
    logic                 w_init;
    logic                 w_final_lane;
    logic [LANE_W-1:0]    w_lane_data;
    logic [WORD_W-1:0]    w_word_shift;

    // The latched word is shifted one lane per write, so the outgoing lane
    // always sits at a fixed end of the register.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_lane_data  = r_word[WORD_W-1 -: LANE_W];
        assign w_word_shift = r_word << LANE_W;
    end else begin : g_lsb_first
        assign w_lane_data  = r_word[LANE_W-1:0];
        assign w_word_shift = r_word >> LANE_W;
    end

    assign w_final_lane = (r_lane == c_LAST_LANE);
    assign w_xfer       = wren & w_ready;
    assign w_init       = start & ((r_state == c_S_IDLE) | (r_state == c_S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_we        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) w_state_nxt = c_S_ACCEPT;
            end
            c_S_ACCEPT: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (wren) w_state_nxt = c_S_UNPACK;
            end
            c_S_UNPACK: begin
                w_busy  = 1'b1;
                w_we    = ~r_overflow;
                w_ready = w_final_lane & ~r_last;
                if (w_final_lane && !(wren && w_ready))
                    w_state_nxt = r_last ? c_S_DONE : c_S_ACCEPT;
            end
            c_S_DONE: begin
                w_done = 1'b1;
                if (start) w_state_nxt = c_S_ACCEPT;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_S_IDLE;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_lane     <= '0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) begin
                r_addr     <= '0;
                r_lane     <= '0;
                r_overflow <= 1'b0;
            end
            if (w_xfer) begin
                r_word <= data;
                r_last <= last;
                r_lane <= '0;
            end else if (r_state == c_S_UNPACK) begin
                r_word <= w_word_shift;
                r_lane <= w_final_lane ? '0 : r_lane + c_LANE_CW'(1);
            end
            // Lanes past the top address still advance the counter but stay unwritten.
            if (r_state == c_S_UNPACK) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_we && (r_addr == c_ADDR_MAX)) r_overflow <= 1'b1;
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_checksum <= 16'h0000;
        end else if (w_init) begin
            r_checksum <= 16'h0000;
        end else if (w_we) begin
            r_checksum <= r_checksum + 16'(w_lane_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

    assign ready     = w_ready;
    assign ram_we    = w_we;
    assign ram_waddr = r_addr;
    assign ram_wdata = w_lane_data;
    assign busy      = w_busy;
    assign done      = w_done;
    assign overflow  = r_overflow;
    assign cpu_hold  = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_load_bridge.sv
// ============================================================================
// Module      : tb_mem_load_bridge
// Description : Self-checking bench for mem_load_bridge (ADDR_W=4 instance)
//               against a byte-list reference model of each loaded image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_load_bridge;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 4;
    localparam int LANES  = WORD_W / LANE_W;
    localparam int SPACE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              wren;
    logic [WORD_W-1:0] data;
    logic              last;
    logic              ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [LANE_W-1:0] ram_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              cpu_hold;
    logic [15:0]       checksum;

    always #5 clk = ~clk;

    mem_load_bridge #(
        .WORD_W   (WORD_W),
        .LANE_W   (LANE_W),
        .ADDR_W   (ADDR_W),
        .MSB_FIRST(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .wren     (wren),
        .data     (data),
        .last     (last),
        .ready    (ready),
        .ram_we   (ram_we),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .cpu_hold (cpu_hold),
        .checksum (checksum)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rdy_cnt = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr.push_back(int'(ram_waddr));
            wr_data.push_back(int'(ram_wdata));
            wr_cyc.push_back(cyc);
        end
        if (ready) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the image is a byte list; byte i goes to address i while i fits.
    task automatic load_image(input string tag, input int n, input bit stream,
                              input bit fixed, input bit mid);
        logic [WORD_W-1:0] words[$];
        int          exp_a[$];
        int          exp_d[$];
        int          total;
        logic [15:0] sum;
        logic [7:0]  b;
        int          acc;
        int          rbase;
        bit          pend;
        bit          got;
        int          m;

        for (int w = 0; w < n; w++)
            words.push_back(fixed ? 32'hAABB_CCDD : WORD_W'($urandom));
        total = n * LANES;
        sum   = 16'h0000;
        for (int i = 0; i < total; i++) begin
            b = 8'(words[i / LANES] >> (LANE_W * (LANES - 1 - (i % LANES))));
            if (i < SPACE) begin
                exp_a.push_back(i);
                exp_d.push_back(int'(b));
                sum = sum + 16'(b);
            end
        end

        @(negedge clk);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        rbase = rdy_cnt;
        start = 1'b1;
        wren  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " accept_flags"}, {59'd0, done, overflow, busy, cpu_hold, ready}, 64'b00111);
        chk({tag, " accept_checksum"}, {48'd0, checksum}, 64'd0);

        pend = 1'b0;
        acc  = -1;
        for (int w = 0; w < n; w++) begin
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                start = pend;
                pend  = 1'b0;
                if (ready && (stream || $urandom_range(0, 2) != 0)) begin
                    wren = 1'b1;
                    data = words[w];
                    last = (w == n - 1);
                    @(posedge clk); #1;
                    got = 1'b1;
                    if (w == 0) begin
                        acc  = cyc;
                        pend = mid;
                    end
                end else begin
                    wren = ready ? 1'b0 : (stream ? 1'b1 : 1'($urandom_range(0, 1)));
                    data = WORD_W'($urandom);
                    last = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                @(negedge clk);
            end
            if (!got) begin
                chk($sformatf("%s word%0d_accept_timeout", tag, w), {63'd0, got}, 64'd1);
                break;
            end
        end
        wren  = 1'b0;
        last  = 1'b0;
        start = 1'b0;

        for (int k = 0; k < 200 && !done; k++) @(negedge clk);
        chk({tag, " done"}, {63'd0, done}, 64'd1);
        @(negedge clk);
        chk({tag, " done_hold_busy_ready"}, {61'd0, cpu_hold, busy, ready}, 64'd0);
        chk({tag, " overflow"}, {63'd0, overflow}, {63'd0, total >= SPACE});
`ifdef LOAD_CHECKSUM_EN
        chk({tag, " checksum"}, {48'd0, checksum}, {48'd0, sum});
`else
        chk({tag, " checksum"}, {48'd0, checksum}, 64'd0);
`endif
        chk({tag, " write_count"}, 64'(wr_addr.size()), 64'(exp_a.size()));
        m = (wr_addr.size() < exp_a.size()) ? wr_addr.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr[i]), 64'(exp_a[i]));
            chk($sformatf("%s data[%0d]", tag, i), 64'(wr_data[i]), 64'(exp_d[i]));
        end
        if (m > 0) begin
            chk({tag, " first_write_latency"}, 64'(wr_cyc[0]), 64'(acc));
            if (stream) begin
                chk({tag, " strobe_gapless"}, 64'(wr_cyc[m-1] - wr_cyc[0]), 64'(m - 1));
                chk({tag, " ready_cycles"}, 64'(rdy_cnt - rbase), 64'(n));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        wren  = 1'b1;
        last  = 1'b1;
        data  = WORD_W'($urandom);
        repeat (2) @(negedge clk);
        chk("reset flags", {58'd0, ready, ram_we, busy, done, overflow, cpu_hold}, 64'd0);
        chk("reset waddr", 64'(ram_waddr), 64'd0);
        chk("reset wdata", 64'(ram_wdata), 64'd0);
        chk("reset checksum", {48'd0, checksum}, 64'd0);
        chk("reset no_writes", 64'(wr_addr.size()), 64'd0);
        reset = 1'b1;
        start = 1'b0;
        wren  = 1'b0;
        last  = 1'b0;
        @(negedge clk);
        chk("idle ready", {63'd0, ready}, 64'd0);

        load_image("single", 1, 1'b1, 1'b1, 1'b0);
        chk("single last_addr", 64'(wr_addr.size() > 0 ? wr_addr[wr_addr.size()-1] : -1), 64'd3);

        load_image("stream3", 3, 1'b1, 1'b0, 1'b0);
        chk("stream3 last_addr", 64'(wr_addr.size() > 0 ? wr_addr[wr_addr.size()-1] : -1), 64'd11);

        load_image("wrap5", 5, 1'b0, 1'b0, 1'b0);
        load_image("restart_midstart", 3, 1'b0, 1'b0, 1'b1);

        // Reset asserted during the second lane of a word.
        @(negedge clk);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wren  = 1'b1;
        data  = WORD_W'($urandom);
        last  = 1'b0;
        @(posedge clk); #1;
        wren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset flags", {59'd0, ram_we, cpu_hold, busy, ready, done}, 64'd0);
        chk("midreset waddr", 64'(ram_waddr), 64'd0);
        chk("midreset writes_before", 64'(wr_addr.size()), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset idle", {62'd0, ready, busy}, 64'd0);
        load_image("after_reset", 2, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++)
            load_image($sformatf("rand%0d", k), $urandom_range(1, 6),
                       1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
